// File: rtl/pipe_stage_reg.sv
// Pipeline register stage with a one-entry skid buffer.
// Carries the ALU result, the store data, the destination index and the control
// bits from one pipeline stage to the next. The stage holds up to two entries.
// MAIN is the head entry and drives out_*. SKID catches the one extra entry
// that arrives while the head is stalled.
// in_ready is decoded from the registered state only, so there is no
// combinational path from out_ready to in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_alu;
  logic [DATA_W-1:0]   r_main_val_rm;
  logic [DEST_W-1:0]   r_main_dest;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_alu;
  logic [DATA_W-1:0]   r_skid_val_rm;
  logic [DEST_W-1:0]   r_skid_dest;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_push;
  logic                w_pop;

  assign w_in_ready  = (r_state != ST_FULL);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = in_valid & w_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  // Occupancy decode: the number of held entries for each state.
  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ST_HALF: occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State machine and slot updates. Flush has priority over push and pop,
  // and clears only the control bits of both slots. The data fields keep
  // their last values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_EMPTY;
      r_main_ctrl   <= '0;
      r_main_alu    <= '0;
      r_main_val_rm <= '0;
      r_main_dest   <= '0;
      r_skid_ctrl   <= '0;
      r_skid_alu    <= '0;
      r_skid_val_rm <= '0;
      r_skid_dest   <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_state       <= ST_HALF;
            r_main_ctrl   <= in_ctrl;
            r_main_alu    <= in_alu;
            r_main_val_rm <= in_val_rm;
            r_main_dest   <= in_dest;
          end
        end
        ST_HALF: begin
          if (w_push && w_pop) begin
            r_main_ctrl   <= in_ctrl;
            r_main_alu    <= in_alu;
            r_main_val_rm <= in_val_rm;
            r_main_dest   <= in_dest;
          end else if (w_push) begin
            r_state       <= ST_FULL;
            r_skid_ctrl   <= in_ctrl;
            r_skid_alu    <= in_alu;
            r_skid_val_rm <= in_val_rm;
            r_skid_dest   <= in_dest;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // A push cannot happen here because in_ready is low.
          if (w_pop) begin
            r_state       <= ST_HALF;
            r_main_ctrl   <= r_skid_ctrl;
            r_main_alu    <= r_skid_alu;
            r_main_val_rm <= r_skid_val_rm;
            r_main_dest   <= r_skid_dest;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  // When there is no head entry, the control bits read as a bubble.
  assign out_ctrl   = w_out_valid ? r_main_ctrl : '0;
  assign out_alu    = r_main_alu;
  assign out_val_rm = r_main_val_rm;
  assign out_dest   = r_main_dest;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random self-checking bench for pipe_stage_reg.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [31:0] in_alu;
  logic [31:0] in_val_rm;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctrl;
  logic [31:0] out_alu;
  logic [31:0] out_val_rm;
  logic [3:0]  out_dest;
  logic [1:0]  occupancy;

  int n_vec;
  int n_bad;

  pipe_stage_reg #(.DATA_W(32), .DEST_W(4), .CTRL_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_val_rm(in_val_rm), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_alu(out_alu), .out_val_rm(out_val_rm), .out_dest(out_dest),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [2:0]  ctrl;
    logic [31:0] alu;
    logic        eov;
    logic        eir;
    logic [1:0]  eocc;
    logic [2:0]  ectrl;
    logic [31:0] ealu;
  } vec_t;

  typedef struct packed {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] v;
    logic [3:0]  d;
  } pl_t;

  vec_t vecs [24];
  pl_t  q [$];

  // One comparison of every output against the expected values.
  task automatic check(input string name, input logic eov, input logic eir,
                       input logic [1:0] eocc, input logic [2:0] ectrl,
                       input logic [31:0] ealu, input logic [31:0] eval,
                       input logic [3:0] edest);
    n_vec++;
    if (out_valid !== eov || in_ready !== eir || occupancy !== eocc ||
        out_ctrl !== ectrl || out_alu !== ealu || out_val_rm !== eval ||
        out_dest !== edest) begin
      n_bad++;
      $display("FAIL %s: got ov=%0b ir=%0b occ=%0d ctrl=%03b alu=%08h val=%08h dest=%0h, want ov=%0b ir=%0b occ=%0d ctrl=%03b alu=%08h val=%08h dest=%0h",
               name, out_valid, in_ready, occupancy, out_ctrl, out_alu, out_val_rm, out_dest,
               eov, eir, eocc, ectrl, ealu, eval, edest);
    end else begin
      $display("ok   %s: ov=%0b ir=%0b occ=%0d ctrl=%03b alu=%08h", name,
               out_valid, in_ready, occupancy, out_ctrl, out_alu);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic ordy,
                       input logic [2:0] c, input logic [31:0] a);
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_ctrl   = c;
    in_alu    = a;
    in_val_rm = ~a;
    in_dest   = a[3:0];
  endtask

  initial begin
    pl_t last;
    pl_t nxt;
    logic push_m;
    logic pop_m;
    logic fl_r;
    logic iv_r;
    logic or_r;

    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);

    // Stimulus table. Each row gives the inputs held for one rising edge and
    // the outputs expected just after that edge. val_rm and dest are derived
    // from alu as ~alu and alu[3:0].
    //            fl iv or ctrl  alu           ov ir occ ectrl  ealu
    // Stream with out_ready high.
    vecs[0]  = '{0,1,1,3'd1,32'h11,        1,1,2'd1,3'd1,32'h11};
    vecs[1]  = '{0,1,1,3'd2,32'h22,        1,1,2'd1,3'd2,32'h22};
    vecs[2]  = '{0,1,1,3'd3,32'h33,        1,1,2'd1,3'd3,32'h33};
    vecs[3]  = '{0,0,1,3'd0,32'h0,         0,1,2'd0,3'd0,32'h33};
    // Bubble: the data fields hold, the control bits read as zero.
    vecs[4]  = '{0,1,1,3'd7,32'h44,        1,1,2'd1,3'd7,32'h44};
    vecs[5]  = '{0,0,1,3'd0,32'h0,         0,1,2'd0,3'd0,32'h44};
    // Backpressure: the third entry is refused while the stage is full.
    vecs[6]  = '{0,1,0,3'd1,32'hAAAA0000,  1,1,2'd1,3'd1,32'hAAAA0000};
    vecs[7]  = '{0,1,0,3'd2,32'hBBBB0000,  1,0,2'd2,3'd1,32'hAAAA0000};
    vecs[8]  = '{0,1,0,3'd4,32'hCCCC0000,  1,0,2'd2,3'd1,32'hAAAA0000};
    vecs[9]  = '{0,1,1,3'd4,32'hCCCC0000,  1,1,2'd1,3'd2,32'hBBBB0000};
    vecs[10] = '{0,0,1,3'd0,32'h0,         0,1,2'd0,3'd0,32'hBBBB0000};
    // Flush from FULL with push and pop both requested.
    vecs[11] = '{0,1,0,3'd1,32'h55,        1,1,2'd1,3'd1,32'h55};
    vecs[12] = '{0,1,0,3'd2,32'h66,        1,0,2'd2,3'd1,32'h55};
    vecs[13] = '{1,1,1,3'd4,32'h77,        0,1,2'd0,3'd0,32'h55};
    vecs[14] = '{0,0,1,3'd0,32'h0,         0,1,2'd0,3'd0,32'h55};
    vecs[15] = '{0,1,1,3'd3,32'h88,        1,1,2'd1,3'd3,32'h88};
    vecs[16] = '{1,1,1,3'd5,32'h99,        0,1,2'd0,3'd0,32'h88};
    vecs[17] = '{0,0,0,3'd0,32'h0,         0,1,2'd0,3'd0,32'h88};
    // HALF hold, HALF push with pop, FULL drain at the extreme data values.
    vecs[18] = '{0,1,0,3'd5,32'h12345678,  1,1,2'd1,3'd5,32'h12345678};
    vecs[19] = '{0,0,0,3'd0,32'h0,         1,1,2'd1,3'd5,32'h12345678};
    vecs[20] = '{0,1,1,3'd6,32'hDEADBEEF,  1,1,2'd1,3'd6,32'hDEADBEEF};
    vecs[21] = '{0,1,0,3'd1,32'hFFFFFFFF,  1,0,2'd2,3'd6,32'hDEADBEEF};
    vecs[22] = '{0,0,1,3'd0,32'h0,         1,1,2'd1,3'd1,32'hFFFFFFFF};
    vecs[23] = '{0,0,1,3'd0,32'h0,         0,1,2'd0,3'd0,32'hFFFFFFFF};

    // Reset state, checked before any clock edge.
    #2;
    check("reset", 1'b0, 1'b1, 2'd0, 3'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].ctrl, vecs[i].alu);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eir, vecs[i].eocc,
            vecs[i].ectrl, vecs[i].ealu, ~vecs[i].ealu, vecs[i].ealu[3:0]);
    end

    // Asynchronous reset while FULL: the outputs clear before any edge.
    drive(1'b0, 1'b1, 1'b0, 3'd3, 32'hA1A1A1A1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 3'd5, 32'hB2B2B2B2);
    @(posedge clk);
    #1;
    check("fill_full", 1'b1, 1'b0, 2'd2, 3'd3, 32'hA1A1A1A1, ~32'hA1A1A1A1, 4'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 1'b0, 1'b1, 2'd0, 3'd0, 32'd0, 32'd0, 4'd0);
    // Hold reset over an edge, then release it between edges with a push waiting.
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 3'd6, 32'h0000005A);
    rst = 1'b1;
    #1;
    check("rst_release", 1'b0, 1'b1, 2'd0, 3'd0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    #1;
    check("first_push", 1'b1, 1'b1, 2'd1, 3'd6, 32'h5A, ~32'h5A, 4'hA);
    // Both entries taken before the reset must be gone, with no partial output.
    drive(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_drain", 1'b0, 1'b1, 2'd0, 3'd0, 32'h5A, ~32'h5A, 4'hA);

    // Random traffic against a queue of at most two entries.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    q.delete();
    last = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      fl_r = ($urandom_range(0, 31) == 0);
      iv_r = $urandom_range(0, 1) == 1;
      or_r = $urandom_range(0, 2) != 0;
      nxt.c = 3'($urandom_range(0, 7));
      nxt.a = $urandom;
      nxt.v = $urandom;
      nxt.d = 4'($urandom_range(0, 15));
      flush = fl_r; in_valid = iv_r; out_ready = or_r;
      in_ctrl = nxt.c; in_alu = nxt.a; in_val_rm = nxt.v; in_dest = nxt.d;
      push_m = iv_r && (q.size() < 2);
      pop_m  = or_r && (q.size() > 0);
      @(posedge clk);
      #1;
      if (fl_r) begin
        q.delete();
      end else begin
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(nxt);
      end
      if (q.size() > 0) last = q[0];
      check($sformatf("rand%0d", cyc), q.size() > 0, q.size() < 2, 2'(q.size()),
            (q.size() > 0) ? last.c : 3'd0, last.a, last.v, last.d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
